// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slave port among four masters (master 0 is the core).
// One access in flight at a time, with a timeout abort if the slave never acks.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [3:0]   m_req_i,
    input  logic [3:0]   m_wen_i,
    input  logic [127:0] m_addr_i,
    input  logic [127:0] m_wdata_i,
    output logic [31:0]  m_rdata_o,
    output logic [3:0]   m_ack_o,
    output logic         m_err_o,
    output logic         s_req_o,
    output logic         s_wen_o,
    output logic [31:0]  s_addr_o,
    output logic [31:0]  s_wdata_o,
    input  logic [31:0]  s_rdata_i,
    input  logic         s_ack_i,
    output logic [1:0]   grant_o,
    output logic         hold_core_o
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

    state_e      state_q;
    logic [1:0]  grant_q;
    logic        s_req_q;
    logic        s_wen_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [3:0]  m_ack_q;
    logic        m_err_q;
    logic [31:0] m_rdata_q;
    logic [7:0]  cnt_q;

    logic [3:0]  eligible;
    logic        found;
    logic [1:0]  winner;
    logic [1:0]  idx;

    // A master acked this cycle is masked so the bus can move on without a gap.
    always_comb begin
        eligible = m_req_i & ~m_ack_q;
        found    = 1'b0;
        winner   = grant_q;
        idx      = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = grant_q + 2'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            grant_q   <= 2'd3;
            s_req_q   <= 1'b0;
            s_wen_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            m_ack_q <= '0;
            m_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_q   <= winner;
                        s_req_q   <= 1'b1;
                        s_wen_q   <= m_wen_i[winner];
                        s_addr_q  <= m_addr_i[{winner, 5'd0} +: 32];
                        s_wdata_q <= m_wdata_i[{winner, 5'd0} +: 32];
                        cnt_q     <= '0;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    if (s_ack_i) begin
                        m_rdata_q        <= s_wen_q ? 32'd0 : s_rdata_i;
                        m_ack_q[grant_q] <= 1'b1;
                        s_req_q          <= 1'b0;
                        state_q          <= StIdle;
                    end else if (cnt_q == CntLast) begin
                        m_rdata_q        <= '0;
                        m_ack_q[grant_q] <= 1'b1;
                        m_err_q          <= 1'b1;
                        s_req_q          <= 1'b0;
                        state_q          <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_rdata_o = m_rdata_q;
    assign m_ack_o   = m_ack_q;
    assign m_err_o   = m_err_q;
    assign s_req_o   = s_req_q;
    assign s_wen_o   = s_wen_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign grant_o   = grant_q;

    // Core stalls on its own pending access and whenever another master owns the bus.
    assign hold_core_o = (m_req_i[0] & ~m_ack_q[0]) | ((state_q == StBusy) & (grant_q != 2'd0));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_mem_arbiter;

    localparam int unsigned TMO = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   m_req = '0;
    logic [3:0]   m_wen = '0;
    logic [127:0] m_addr = '0;
    logic [127:0] m_wdata = '0;
    logic [31:0]  s_rdata = '0;
    logic         s_ack = 1'b0;
    logic [31:0]  m_rdata_o;
    logic [3:0]   m_ack_o;
    logic         m_err_o;
    logic         s_req_o;
    logic         s_wen_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_wdata_o;
    logic [1:0]   grant_o;
    logic         hold_core_o;

    int n_total = 0;
    int n_bad = 0;

    mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m_req_i     (m_req),
        .m_wen_i     (m_wen),
        .m_addr_i    (m_addr),
        .m_wdata_i   (m_wdata),
        .m_rdata_o   (m_rdata_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .s_req_o     (s_req_o),
        .s_wen_o     (s_wen_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_rdata_i   (s_rdata),
        .s_ack_i     (s_ack),
        .grant_o     (grant_o),
        .hold_core_o (hold_core_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction owner at a time, expressed as who owns the bus,
    // how many BUSY cycles have elapsed and what the owner asked for.
    logic        md_busy;
    int          md_owner;
    int          md_waited;
    logic        md_wen;
    logic [31:0] md_addr;
    logic [31:0] md_wdata;
    logic [3:0]  md_ack;
    logic        md_err;
    logic [31:0] md_rdata;
    logic [3:0]  md_acked_now;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            md_busy = 1'b0; md_owner = 3; md_waited = 0;
            md_wen = 1'b0; md_addr = '0; md_wdata = '0;
            md_ack = '0; md_err = 1'b0; md_rdata = '0;
        end else begin
            md_acked_now = md_ack;
            md_ack = '0;
            md_err = 1'b0;
            if (!md_busy) begin
                for (int k = 1; k <= 4; k++) begin
                    int m;
                    m = (md_owner + k) % 4;
                    if (!md_busy && m_req[m] && !md_acked_now[m]) begin
                        md_busy = 1'b1;
                        md_owner = m;
                        md_waited = 0;
                        md_wen = m_wen[m];
                        md_addr = m_addr[32*m +: 32];
                        md_wdata = m_wdata[32*m +: 32];
                    end
                end
            end else begin
                md_waited++;
                if (s_ack) begin
                    md_ack[md_owner] = 1'b1;
                    md_rdata = md_wen ? 32'd0 : s_rdata;
                    md_busy = 1'b0;
                end else if (md_waited == int'(TMO)) begin
                    md_ack[md_owner] = 1'b1;
                    md_err = 1'b1;
                    md_rdata = '0;
                    md_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_s_req", 32'(s_req_o), 32'(md_busy));
        check("m_s_wen", 32'(s_wen_o), 32'(md_wen));
        check("m_s_addr", s_addr_o, md_addr);
        check("m_s_wdata", s_wdata_o, md_wdata);
        check("m_ack", 32'(m_ack_o), 32'(md_ack));
        check("m_err", 32'(m_err_o), 32'(md_err));
        check("m_rdata", m_rdata_o, md_rdata);
        check("m_grant", 32'(grant_o), 32'(md_owner));
        check("m_hold", 32'(hold_core_o),
              32'((m_req[0] && !md_ack[0]) || (md_busy && md_owner != 0)));
    end

    // Slave: acks after sl_lat BUSY cycles (0 = never).
    int          sl_cnt = 0;
    int          sl_lat = 1;
    logic        sl_fixed_en = 1'b0;
    logic [31:0] sl_fixed = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (s_req_o) begin
            sl_cnt++;
            s_ack = (sl_lat != 0) && (sl_cnt == sl_lat);
        end else begin
            sl_cnt = 0;
            s_ack = 1'b0;
        end
        s_rdata = sl_fixed_en ? sl_fixed : ~s_addr_o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #300000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        int rr_got[$];
        int rr_exp[6];
        int ack_cyc;
        int sreq_cyc;
        rr_exp = '{0, 1, 2, 3, 0, 1};

        do_reset();
        check("rst_grant", 32'(grant_o), 32'd3);
        check("rst_sreq", 32'(s_req_o), 32'd0);
        check("rst_ack", 32'(m_ack_o), 32'd0);
        check("rst_hold", 32'(hold_core_o), 32'd0);

        // Single read by the core.
        sl_lat = 1; sl_fixed_en = 1'b1; sl_fixed = 32'hDEAD_BEEF;
        m_req = 4'b0001; m_wen = '0; m_addr[31:0] = 32'h0000_0100;
        #1;
        check("rd_hold_c0", 32'(hold_core_o), 32'd1);
        tick();
        check("rd_sreq_c1", 32'(s_req_o), 32'd1);
        check("rd_hold_c1", 32'(hold_core_o), 32'd1);
        tick();
        check("rd_ack_c2", 32'(m_ack_o), 32'h1);
        check("rd_data_c2", m_rdata_o, 32'hDEAD_BEEF);
        check("rd_hold_c2", 32'(hold_core_o), 32'd0);
        m_req = '0;
        idle(2);

        // Round-robin with everyone requesting.
        do_reset();
        sl_fixed_en = 1'b0; sl_lat = 1;
        for (int n = 0; n < 4; n++) m_addr[32*n +: 32] = 32'h1000 * (n + 1);
        m_req = 4'b1111;
        for (int c = 0; c < 40 && rr_got.size() < 6; c++) begin
            tick();
            if (m_ack_o != 4'd0) begin
                check("rr_onehot", 32'($onehot(m_ack_o)), 32'd1);
                for (int k = 0; k < 4; k++) if (m_ack_o[k]) rr_got.push_back(k);
            end
        end
        check("rr_count", 32'(rr_got.size()), 32'd6);
        for (int i = 0; i < rr_got.size() && i < 6; i++) check("rr_order", 32'(rr_got[i]), 32'(rr_exp[i]));
        m_req = '0;
        idle(4);

        // Foreign owner: m2 writes with a 3-cycle slave.
        sl_lat = 3;
        m_req = 4'b0100; m_wen = 4'b0100;
        m_addr[95:64] = 32'h2000_0000; m_wdata[95:64] = 32'h55;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("fo_hold", 32'(hold_core_o), 32'd1);
            check("fo_wdata", s_wdata_o, 32'h55);
            check("fo_wen", 32'(s_wen_o), 32'd1);
            check("fo_sreq", 32'(s_req_o), 32'd1);
        end
        tick();
        check("fo_ack", 32'(m_ack_o), 32'b0100);
        check("fo_rdata", m_rdata_o, 32'd0);
        m_req = '0; m_wen = '0;
        idle(2);

        // Timeout: m1 reads, slave silent.
        sl_lat = 0;
        m_req = 4'b0010; m_addr[63:32] = 32'h3000_0040;
        ack_cyc = -1; sreq_cyc = 0;
        for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
            tick();
            if (s_req_o) sreq_cyc++;
            if (m_ack_o != 4'd0) begin
                ack_cyc = c;
                check("to_ack", 32'(m_ack_o), 32'b0010);
                check("to_err", 32'(m_err_o), 32'd1);
                check("to_rdata", m_rdata_o, 32'd0);
            end
        end
        check("to_cycle", 32'(ack_cyc), 32'(TMO + 1));
        check("to_busy_len", 32'(sreq_cyc), 32'(TMO));
        m_req = '0;
        tick();
        sl_lat = 1; sl_fixed_en = 1'b1; sl_fixed = 32'h1234_5678;
        m_req = 4'b0010;
        tick();
        tick();
        check("to_next_ack", 32'(m_ack_o), 32'b0010);
        check("to_next_err", 32'(m_err_o), 32'd0);
        check("to_next_data", m_rdata_o, 32'h1234_5678);
        m_req = '0;
        idle(2);

        // Payload change mid-BUSY, then a stray slave ack while idle.
        sl_lat = 3; sl_fixed_en = 1'b0;
        m_req = 4'b1000; m_addr[127:96] = 32'h4000_0010;
        tick();
        check("pc_addr_c1", s_addr_o, 32'h4000_0010);
        m_req = '0; m_addr[127:96] = 32'hFFFF_FFF0;
        tick();
        check("pc_addr_c2", s_addr_o, 32'h4000_0010);
        check("pc_sreq_c2", 32'(s_req_o), 32'd1);
        tick();
        tick();
        check("pc_ack", 32'(m_ack_o), 32'b1000);
        tick();
        s_ack = 1'b1;
        tick();
        check("stray_ack", 32'(m_ack_o), 32'd0);
        check("stray_sreq", 32'(s_req_o), 32'd0);
        idle(2);

        // Reset in the middle of a hung access.
        sl_lat = 0;
        m_req = 4'b0001; m_addr[31:0] = 32'h0000_0500;
        tick();
        tick();
        check("rb_busy", 32'(s_req_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("rb_sreq_drop", 32'(s_req_o), 32'd0);
        check("rb_no_ack", 32'(m_ack_o), 32'd0);
        m_req = 4'b0011; m_addr[63:32] = 32'h0000_0600; sl_lat = 1;
        tick();
        check("rb_no_ack_rst", 32'(m_ack_o), 32'd0);
        rstn = 1'b1;
        tick();
        check("rb_grant", 32'(grant_o), 32'd0);
        check("rb_addr", s_addr_o, 32'h0000_0500);
        tick();
        check("rb_ack", 32'(m_ack_o), 32'b0001);
        m_req = 4'b0010;
        tick();
        check("rb_next_grant", 32'(grant_o), 32'd1);
        m_req = '0;
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
